// File: rtl/accel_frame_ctrl.sv
// Frame buffer, launch and result-collection controller for the LeNet-5 core.
// Define ARGMAX_EN to build the running argmax (cls_valid/cls_idx/cls_score).
module accel_frame_ctrl #(
  parameter int DWIDTH      = 16,
  parameter int IMG_SIZE    = 30,
  parameter int NUM_CLASSES = 10,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CLS_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              core_din_st,
  output logic [DWIDTH-1:0] core_din,
  input  logic              core_dout_st,
  input  logic [DWIDTH-1:0] core_dout,
  output logic              res_valid,
  output logic [DWIDTH-1:0] res_data,
  output logic              res_last,
  output logic              cls_valid,
  output logic [CLS_W-1:0]  cls_idx,
  output logic [DWIDTH-1:0] cls_score,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              timeout_err
);

  localparam int N  = IMG_SIZE * IMG_SIZE;
  localparam int AW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(NUM_CLASSES + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_COLL   = 2'd3;

  logic [1:0]        state;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic [RW-1:0]     res_cnt;
  logic [WW-1:0]     wd_cnt;
  logic [DWIDTH-1:0] mem [N];
  logic [DWIDTH-1:0] ram_q;
  logic              dout_v;
  logic              st_q;

  logic accept;
  logic rd_go;
  logic first_rd;
  logic cap;
  logic last_cap;
  logic wd_fire;

  assign s_ready  = (state == S_FILL);
  assign busy     = ~s_ready;
  assign accept   = s_ready & s_valid;
  assign rd_go    = (state == S_LAUNCH) && (rd_addr != AW'(N));
  assign first_rd = rd_go && (rd_addr == '0);
  assign cap      = ((state == S_WAIT) && core_dout_st) ||
                    ((state == S_COLL) && (res_cnt != RW'(NUM_CLASSES)));
  assign last_cap = (state == S_COLL) &&
                    (res_cnt == RW'(NUM_CLASSES - 1));
  assign wd_fire  = (state == S_WAIT) && !core_dout_st &&
                    (wd_cnt == WW'(TIMEOUT_CYC - 1));

  assign core_din_st = st_q;
  assign core_din    = dout_v ? ram_q : '0;

  // Frame RAM: writes only in FILL, reads only in LAUNCH.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr[IW-1:0]] <= s_data;
    if (rd_go)  ram_q <= mem[rd_addr[IW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FILL;
      wr_addr     <= '0;
      rd_addr     <= '0;
      res_cnt     <= '0;
      wd_cnt      <= '0;
      dout_v      <= 1'b0;
      st_q        <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_last    <= 1'b0;
      frame_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      dout_v    <= rd_go;
      st_q      <= first_rd;
      res_valid <= cap;
      res_last  <= last_cap;
      if (cap) res_data <= core_dout;

      if (first_rd)     timeout_err <= 1'b0;
      else if (wd_fire) timeout_err <= 1'b1;

      unique case (state)
        S_FILL: begin
          if (accept) begin
            if (wr_addr == AW'(N - 1)) begin
              wr_addr <= '0;
              rd_addr <= '0;
              state   <= S_LAUNCH;
            end else begin
              wr_addr <= wr_addr + AW'(1);
            end
          end
        end
        S_LAUNCH: begin
          // Extra cycle lets the last pixel leave the RAM before WAIT.
          if (rd_addr == AW'(N)) begin
            rd_addr <= '0;
            wd_cnt  <= '0;
            state   <= S_WAIT;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        S_WAIT: begin
          if (core_dout_st) begin
            res_cnt <= RW'(1);
            state   <= S_COLL;
          end else if (wd_fire) begin
            state <= S_FILL;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        S_COLL: begin
          // Stay through the res_last cycle so s_ready rises after it.
          if (res_cnt == RW'(NUM_CLASSES)) begin
            res_cnt   <= '0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= S_FILL;
          end else begin
            res_cnt <= res_cnt + RW'(1);
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

`ifdef ARGMAX_EN
  logic [DWIDTH-1:0] max_q;
  logic [CLS_W-1:0]  max_idx;
  logic              coll_done;

  assign coll_done = (state == S_COLL) &&
                     (res_cnt == RW'(NUM_CLASSES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q     <= '0;
      max_idx   <= '0;
      cls_valid <= 1'b0;
      cls_idx   <= '0;
      cls_score <= '0;
    end else begin
      cls_valid <= coll_done;
      if (coll_done) begin
        cls_idx   <= max_idx;
        cls_score <= max_q;
      end
      // Result 0 seeds the max; strict compare keeps the lowest index on ties.
      if ((state == S_WAIT) && core_dout_st) begin
        max_q   <= core_dout;
        max_idx <= '0;
      end else if (cap && ($signed(core_dout) > $signed(max_q))) begin
        max_q   <= core_dout;
        max_idx <= CLS_W'(res_cnt);
      end
    end
  end
`else
  assign cls_valid = 1'b0;
  assign cls_idx   = '0;
  assign cls_score = '0;
`endif

endmodule

// File: tb/tb_accel_frame_ctrl.sv
// Directed bench for accel_frame_ctrl (4x4 frames, 10 classes, 100-cycle watchdog).
// Frame records drive fill, launch and collect; timeout and reset are hand sequences.
module tb_accel_frame_ctrl;

  localparam int NPIX = 16;
  localparam int NCLS = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        core_din_st;
  logic [15:0] core_din;
  logic        core_dout_st;
  logic [15:0] core_dout;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_last;
  logic        cls_valid;
  logic [3:0]  cls_idx;
  logic [15:0] cls_score;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        timeout_err;

  accel_frame_ctrl #(
    .DWIDTH(16), .IMG_SIZE(4), .NUM_CLASSES(NCLS),
    .TIMEOUT_CYC(100), .CLS_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_din_st(core_din_st), .core_din(core_din),
    .core_dout_st(core_dout_st), .core_dout(core_dout),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
    .cls_valid(cls_valid), .cls_idx(cls_idx), .cls_score(cls_score),
    .busy(busy), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      base;
    logic [9:0][15:0] res;
    logic [3:0]       exp_idx;
    logic [15:0]      exp_score;
    logic             gappy;
    logic             noise;
    logic             st_mid;
    logic [3:0]       dly;
  } vec_t;

  vec_t        tbl [4];
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_fc = '0;
  logic        exp_err = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill pixels base+i, then follow the launch; returns in the first WAIT cycle.
  task automatic fill_launch(input logic [15:0] base, input logic gappy,
                             input logic noise, input int abort_at);
    int  i;
    logic gap;
    i = 0;
    gap = 1'b0;
    core_dout_st = noise;
    while (i < NPIX) begin
      if (gappy && gap) begin
        s_valid = 1'b0;
        s_data  = 16'hdead;
      end else begin
        s_valid = 1'b1;
        s_data  = base + 16'(i);
        chk("fill_s_ready", 16'(s_ready), 16'd1);
        i++;
      end
      tick();
      gap = ~gap;
    end
    s_valid = 1'b0;
    s_data  = 16'h0;
    chk("s_ready_drop", 16'(s_ready), 16'd0);
    chk("busy_launch", 16'(busy), 16'd1);
    chk("st_early", 16'(core_din_st), 16'd0);
    chk("err_hold", 16'(timeout_err), 16'(exp_err));
    tick();
    chk("din_st", 16'(core_din_st), 16'd1);
    chk("din_p0", core_din, base);
    chk("err_clr", 16'(timeout_err), 16'd0);
    exp_err = 1'b0;
    for (int j = 1; j < NPIX; j++) begin
      tick();
      chk("din_st_once", 16'(core_din_st), 16'd0);
      chk("din_seq", core_din, base + 16'(j));
      chk("no_res_launch", 16'(res_valid), 16'd0);
      if (j == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_st", 16'(core_din_st), 16'd0);
        chk("rst_din", core_din, 16'd0);
        chk("rst_res_valid", 16'(res_valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_s_ready", 16'(s_ready), 16'd1);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        core_dout_st = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_fc = '0;
        exp_err = 1'b0;
        return;
      end
    end
    tick();
    core_dout_st = 1'b0;
    chk("wait_din", core_din, 16'd0);
    chk("wait_busy", 16'(busy), 16'd1);
    chk("wait_res_valid", 16'(res_valid), 16'd0);
  endtask

  task automatic collect(input vec_t v);
    repeat (int'(v.dly)) begin
      chk("wait_idle", 16'(res_valid), 16'd0);
      tick();
    end
    core_dout_st = 1'b1;
    core_dout    = v.res[0];
    for (int k = 1; k < NCLS; k++) begin
      tick();
      core_dout_st = v.st_mid && (k == 4);
      core_dout    = v.res[k];
      chk("res_valid", 16'(res_valid), 16'd1);
      chk("res_data", res_data, v.res[k-1]);
      chk("res_last_early", 16'(res_last), 16'd0);
    end
    tick();
    core_dout_st = 1'b0;
    core_dout    = 16'h0;
    chk("res_valid_last", 16'(res_valid), 16'd1);
    chk("res_data_last", res_data, v.res[NCLS-1]);
    chk("res_last", 16'(res_last), 16'd1);
    chk("s_ready_at_last", 16'(s_ready), 16'd0);
    tick();
    exp_fc = exp_fc + 16'd1;
    chk("res_valid_end", 16'(res_valid), 16'd0);
    chk("s_ready_rise", 16'(s_ready), 16'd1);
    chk("busy_end", 16'(busy), 16'd0);
    chk("frame_cnt", frame_cnt, exp_fc);
`ifdef ARGMAX_EN
    chk("cls_valid", 16'(cls_valid), 16'd1);
    chk("cls_idx", 16'(cls_idx), 16'(v.exp_idx));
    chk("cls_score", cls_score, v.exp_score);
`else
    chk("cls_valid_off", 16'(cls_valid), 16'd0);
    chk("cls_idx_off", 16'(cls_idx), 16'd0);
    chk("cls_score_off", cls_score, 16'd0);
`endif
    tick();
    chk("cls_valid_pulse", 16'(cls_valid), 16'd0);
`ifdef ARGMAX_EN
    chk("cls_idx_hold", 16'(cls_idx), 16'(v.exp_idx));
`endif
  endtask

  task automatic timeout_wait();
    repeat (99) tick();
    chk("wd_not_yet", 16'(timeout_err), 16'd0);
    chk("wd_busy", 16'(busy), 16'd1);
    tick();
    chk("wd_fire", 16'(timeout_err), 16'd1);
    chk("wd_s_ready", 16'(s_ready), 16'd1);
    chk("wd_frame_cnt", frame_cnt, exp_fc);
    chk("wd_res_valid", 16'(res_valid), 16'd0);
    exp_err = 1'b1;
    tick();
    chk("wd_sticky", 16'(timeout_err), 16'd1);
    chk("wd_s_ready2", 16'(s_ready), 16'd1);
  endtask

  initial begin
    int r0 [10] = '{5, -3, 9, 9, 2, 0, 1, -8, 4, 7};
    int r3 [10] = '{-32768, 32767, 0, 32767, -1, -1, -1, -1, -1, -1};

    tbl[0] = '0;
    tbl[0].base = 16'h0000;
    tbl[0].exp_idx = 4'd2;
    tbl[0].exp_score = 16'd9;
    tbl[0].st_mid = 1'b1;
    tbl[1] = '0;
    tbl[1].base = 16'h0100;
    tbl[1].exp_idx = 4'd9;
    tbl[1].exp_score = 16'(-11);
    tbl[1].gappy = 1'b1;
    tbl[1].dly = 4'd3;
    tbl[2] = '0;
    tbl[2].base = 16'h0200;
    tbl[2].exp_idx = 4'd0;
    tbl[2].exp_score = 16'd7;
    tbl[2].noise = 1'b1;
    tbl[2].dly = 4'd2;
    tbl[3] = '0;
    tbl[3].base = 16'hfff0;
    tbl[3].exp_idx = 4'd1;
    tbl[3].exp_score = 16'h7fff;
    tbl[3].dly = 4'd1;
    for (int k = 0; k < NCLS; k++) begin
      tbl[0].res[k] = 16'(r0[k]);
      tbl[1].res[k] = 16'(-20 + k);
      tbl[2].res[k] = 16'd7;
      tbl[3].res[k] = 16'(r3[k]);
    end

    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    core_dout_st = 1'b0;
    core_dout = '0;
    #1;
    chk("reset_s_ready", 16'(s_ready), 16'd1);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_din_st", 16'(core_din_st), 16'd0);
    chk("reset_din", core_din, 16'd0);
    chk("reset_res_valid", 16'(res_valid), 16'd0);
    chk("reset_res_last", 16'(res_last), 16'd0);
    chk("reset_frame_cnt", frame_cnt, 16'd0);
    chk("reset_err", 16'(timeout_err), 16'd0);
    chk("reset_cls_valid", 16'(cls_valid), 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int f = 0; f < 4; f++) begin
      fill_launch(tbl[f].base, tbl[f].gappy, tbl[f].noise, -1);
      collect(tbl[f]);
    end

    fill_launch(16'h0300, 1'b0, 1'b0, -1);
    timeout_wait();
    fill_launch(16'h0400, 1'b0, 1'b0, -1);
    collect(tbl[0]);

    fill_launch(16'h0500, 1'b0, 1'b0, 7);
    fill_launch(16'h0600, 1'b1, 1'b0, -1);
    collect(tbl[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/accel_frame_ctrl.md
Name: accel_frame_ctrl

Overview:
- Frame-level controller for the next-generation LeNet-5 accelerator. It accepts pixels over a valid/ready stream and buffers one full frame.
- It replays the frame contiguously into the non-stallable conv/FC core through the core's start-strobe interface.
- It collects the NUM_CLASSES core results as a stream and, optionally, reports argmax class and score.
- It adds backpressure, frame counting, busy indication and a result watchdog to the core-only top.

Parameters:
- DWIDTH, 16, pixel/result width (signed fixed-point).
- IMG_SIZE, 30, frame side; frame length N = IMG_SIZE*IMG_SIZE.
- NUM_CLASSES, 10, results emitted by core per frame.
- TIMEOUT_CYC, 65535, max cycles in WAIT before watchdog fires.
- CLS_W, 4, class index width (must satisfy 2^CLS_W >= NUM_CLASSES).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  controller can accept pixel.
- s_data  in  DWIDTH  signed pixel.
- core_din_st  out  1  one-cycle start strobe, coincident with pixel 0.
- core_din  out  DWIDTH  pixel to core.
- core_dout_st  in  1  core strobe, coincident with result 0.
- core_dout  in  DWIDTH  core result; results 1..NUM_CLASSES-1 follow on consecutive cycles.
- res_valid  out  1  result stream valid.
- res_data  out  DWIDTH  registered copy of core_dout.
- res_last  out  1  high with result NUM_CLASSES-1.
- cls_valid  out  1  one-cycle argmax valid.
- cls_idx  out  CLS_W  argmax class index.
- cls_score  out  DWIDTH  argmax score.
- busy  out  1  high in any state except FILL.
- frame_cnt  out  16  completed frames, wraps 65535->0.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset: state=FILL. All addresses and counters are 0. All outputs are 0 except s_ready=1. The reset is asynchronous; asserting rst_n low mid-frame discards all state with no partial output.
- Buffer: N-deep DWIDTH RAM, synchronous read, single port is sufficient.
- FILL: s_ready=1. A pixel is accepted when s_valid&s_ready, written at wr_addr, and wr_addr increments. Accepting pixel N-1 (cycle T) moves to LAUNCH; s_ready drops at T+1.
- LAUNCH: buffer is read sequentially. core_din_st=1 and core_din=pixel0 at T+2. Pixels 1..N-1 follow on T+3..T+N+1 with no gaps. core_din_st is high exactly one cycle. core_din is held at 0 outside LAUNCH. After the last pixel, state moves to WAIT.
- WAIT: wd_cnt counts from 0. On core_dout_st, state moves to COLLECT and result 0 is captured the same cycle.
- If wd_cnt reaches TIMEOUT_CYC with no strobe: set timeout_err, leave frame_cnt unchanged, go to FILL. timeout_err stays set until the next core_din_st.
- core_dout_st in FILL/LAUNCH is ignored.
- COLLECT: res_cnt 0..NUM_CLASSES-1 captures core_dout each cycle. res_valid/res_data are asserted 1 cycle after capture, and res_last accompanies index NUM_CLASSES-1. A core_dout_st re-assertion during COLLECT is treated as plain data.
- After the last capture: frame_cnt increments and state moves to FILL.
- s_ready rises the cycle after res_last. The next frame's fill may therefore overlap cls_valid.
- busy=1 in LAUNCH, WAIT and COLLECT.
- No result backpressure: the downstream consumer must accept res_valid every cycle.

Optional Feature:
- ARGMAX_EN defined:
  - Running max register, signed compare, strict greater-than. Ties keep the lowest index.
  - Result 0 initialises max (no reset-value bias).
  - cls_valid pulses one cycle after res_last, with cls_idx/cls_score stable until the next cls_valid.
- ARGMAX_EN undefined: no compare logic is built; cls_valid, cls_idx and cls_score are tied to 0.

Test Plan:
- IMG_SIZE=4, continuous s_valid, pixels 0..15:
  - s_ready low at the cycle after pixel 15.
  - core_din_st one cycle, 2 cycles after last accept, with core_din=0, then 1..15 contiguous.
  - busy=1 from that cycle.
- Stub core returns 5,-3,9,9,2,0,1,-8,4,7 (NUM_CLASSES=10):
  - res_data echoes these 1 cycle later, with res_last on 7.
  - frame_cnt=1.
  - With ARGMAX_EN: cls_idx=2, cls_score=9 (tie, lowest index).
- All-negative results -20..-11 (ascending) with ARGMAX_EN -> cls_idx=9, cls_score=-11.
- Stub core never responds, TIMEOUT_CYC=100:
  - timeout_err=1 exactly 100 cycles after WAIT entry.
  - s_ready=1 next cycle, frame_cnt unchanged.
  - Next frame's core_din_st clears timeout_err.
- Gappy upstream, s_valid toggling 1/0 for a 16-pixel frame -> only accepted pixels are stored, launch order is preserved, and no pixel is dropped or duplicated.
- rst_n pulsed low during LAUNCH (pixel 7) -> core_din_st, res_valid and busy are 0 immediately, s_ready=1, frame_cnt=0; a new full frame then processes normally.
